// File: rtl/cpu7_excp_ctl_pkg.sv
// Shared exception codes, state encoding and default widths for the E-stage exception controller.
package cpu7_excp_ctl_pkg;

  localparam int unsigned EcodeWDefault = 6;

  localparam logic [5:0] EcodeIne = 6'h0D;
  localparam logic [5:0] EcodeBrk = 6'h0C;
  localparam logic [5:0] EcodeSys = 6'h0B;
  localparam logic [5:0] EcodeAle = 6'h09;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StCommit = 2'd1,
    StFlush  = 2'd2,
    StRedir  = 2'd3
  } excp_state_e;

endpackage

// File: rtl/cpu7_excp_ctl_prio.sv
// Combinational priority encoder: E-stage requests -> hit, ecode, is_ertn.
module cpu7_excp_ctl_prio
  import cpu7_excp_ctl_pkg::*;
#(
  parameter int unsigned ECODE_W = EcodeWDefault
) (
  input  logic               valid,
  input  logic               ine,
  input  logic               brk,
  input  logic               sys,
  input  logic               ale,
  input  logic               ertn,
  output logic               hit,
  output logic [ECODE_W-1:0] ecode,
  output logic               is_ertn
);

  logic any_excp;

  assign any_excp = ine | brk | sys | ale;

  always_comb begin
    hit     = 1'b0;
    ecode   = '0;
    is_ertn = 1'b0;
    if (valid) begin
      hit = any_excp | ertn;
      if (ine) begin
        ecode = ECODE_W'(EcodeIne);
      end else if (brk) begin
        ecode = ECODE_W'(EcodeBrk);
      end else if (sys) begin
        ecode = ECODE_W'(EcodeSys);
      end else if (ale) begin
        ecode = ECODE_W'(EcodeAle);
      end else begin
        is_ertn = ertn;
      end
    end
  end

endmodule

// File: rtl/cpu7_excp_ctl.sv
// E-stage exception/ERTN controller: commit pulse to CSR, pipeline flush, IFU redirect.
// Optional faulting-address capture enabled by defining EXCP_BADV_EN.
module cpu7_excp_ctl
  import cpu7_excp_ctl_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned ECODE_W      = EcodeWDefault,
  parameter int unsigned GRLEN        = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               ecl_valid_e,
  input  logic               ecl_excp_ine_e,
  input  logic               ecl_excp_brk_e,
  input  logic               ecl_excp_sys_e,
  input  logic               ecl_excp_ale_e,
  input  logic               ecl_ertn_e,
  input  logic [GRLEN-1:0]   ifu_exu_pc_e,
  input  logic [GRLEN-1:0]   exu_badv_e,
  input  logic [GRLEN-1:0]   csr_eentry,
  input  logic [GRLEN-1:0]   csr_era,
  output logic               excp_csr_commit,
  output logic               excp_csr_ertn,
  output logic [ECODE_W-1:0] excp_csr_ecode,
  output logic [GRLEN-1:0]   excp_csr_pc,
  output logic [GRLEN-1:0]   excp_csr_badv,
  output logic               excp_flush,
  output logic               excp_ifu_redirect_vld,
  output logic [GRLEN-1:0]   excp_ifu_redirect_pc,
  input  logic               ifu_excp_redirect_rdy,
  output logic               excp_busy
);

  localparam int unsigned CntW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) + 1 : 1;

  excp_state_e        state_q;
  logic [CntW-1:0]    cnt_q;
  logic [GRLEN-1:0]   target_q;
  logic               commit_q, ertn_q, flush_q, vld_q;
  logic [ECODE_W-1:0] ecode_q;
  logic [GRLEN-1:0]   pc_q, redir_pc_q;

  logic               hit, is_ertn, accept;
  logic [ECODE_W-1:0] ecode;

  cpu7_excp_ctl_prio #(
    .ECODE_W (ECODE_W)
  ) u_prio (
    .valid   (ecl_valid_e),
    .ine     (ecl_excp_ine_e),
    .brk     (ecl_excp_brk_e),
    .sys     (ecl_excp_sys_e),
    .ale     (ecl_excp_ale_e),
    .ertn    (ecl_ertn_e),
    .hit     (hit),
    .ecode   (ecode),
    .is_ertn (is_ertn)
  );

  // E-stage requests only matter while idle; anything arriving during busy is dropped.
  assign accept = (state_q == StIdle) & hit;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      target_q   <= '0;
      commit_q   <= 1'b0;
      ertn_q     <= 1'b0;
      flush_q    <= 1'b0;
      vld_q      <= 1'b0;
      ecode_q    <= '0;
      pc_q       <= '0;
      redir_pc_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            target_q <= is_ertn ? csr_era : csr_eentry;
            commit_q <= ~is_ertn;
            ertn_q   <= is_ertn;
            flush_q  <= 1'b1;
            if (!is_ertn) begin
              ecode_q <= ecode;
              pc_q    <= ifu_exu_pc_e;
            end
            state_q <= StCommit;
          end
        end
        StCommit: begin
          commit_q <= 1'b0;
          ertn_q   <= 1'b0;
          if (FLUSH_CYCLES <= 1) begin
            flush_q    <= 1'b0;
            vld_q      <= 1'b1;
            redir_pc_q <= target_q;
            state_q    <= StRedir;
          end else begin
            cnt_q   <= CntW'(FLUSH_CYCLES - 1);
            state_q <= StFlush;
          end
        end
        StFlush: begin
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == CntW'(1)) begin
            flush_q    <= 1'b0;
            vld_q      <= 1'b1;
            redir_pc_q <= target_q;
            state_q    <= StRedir;
          end
        end
        StRedir: begin
          if (ifu_excp_redirect_rdy) begin
            vld_q      <= 1'b0;
            redir_pc_q <= '0;
            state_q    <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

`ifdef EXCP_BADV_EN
  logic [GRLEN-1:0] badv_q;

  // Only ALE carries a meaningful address; other exceptions leave the last value in place.
  always_ff @(posedge clk) begin
    if (reset) begin
      badv_q <= '0;
    end else if (accept && !is_ertn && ecode == ECODE_W'(EcodeAle)) begin
      badv_q <= exu_badv_e;
    end
  end

  assign excp_csr_badv = badv_q;
`else
  logic unused_badv;

  assign unused_badv   = ^exu_badv_e;
  assign excp_csr_badv = '0;
`endif

  assign excp_csr_commit       = commit_q;
  assign excp_csr_ertn         = ertn_q;
  assign excp_csr_ecode        = ecode_q;
  assign excp_csr_pc           = pc_q;
  assign excp_flush            = flush_q;
  assign excp_ifu_redirect_vld = vld_q;
  assign excp_ifu_redirect_pc  = redir_pc_q;
  assign excp_busy             = (state_q != StIdle);

endmodule

// File: tb/tb_cpu7_excp_ctl.sv
// Directed self-checking bench for cpu7_excp_ctl (FLUSH_CYCLES=2, GRLEN=32).
module tb_cpu7_excp_ctl;

  logic        clk = 1'b0;
  logic        reset;
  logic        ecl_valid_e, ecl_excp_ine_e, ecl_excp_brk_e, ecl_excp_sys_e, ecl_excp_ale_e;
  logic        ecl_ertn_e;
  logic [31:0] ifu_exu_pc_e, exu_badv_e, csr_eentry, csr_era;
  logic        excp_csr_commit, excp_csr_ertn;
  logic [5:0]  excp_csr_ecode;
  logic [31:0] excp_csr_pc, excp_csr_badv, excp_ifu_redirect_pc;
  logic        excp_flush, excp_ifu_redirect_vld, ifu_excp_redirect_rdy, excp_busy;

  int checks = 0;
  int errors = 0;

  cpu7_excp_ctl #(
    .FLUSH_CYCLES (2),
    .ECODE_W      (6),
    .GRLEN        (32)
  ) dut (
    .clk                   (clk),
    .reset                 (reset),
    .ecl_valid_e           (ecl_valid_e),
    .ecl_excp_ine_e        (ecl_excp_ine_e),
    .ecl_excp_brk_e        (ecl_excp_brk_e),
    .ecl_excp_sys_e        (ecl_excp_sys_e),
    .ecl_excp_ale_e        (ecl_excp_ale_e),
    .ecl_ertn_e            (ecl_ertn_e),
    .ifu_exu_pc_e          (ifu_exu_pc_e),
    .exu_badv_e            (exu_badv_e),
    .csr_eentry            (csr_eentry),
    .csr_era               (csr_era),
    .excp_csr_commit       (excp_csr_commit),
    .excp_csr_ertn         (excp_csr_ertn),
    .excp_csr_ecode        (excp_csr_ecode),
    .excp_csr_pc           (excp_csr_pc),
    .excp_csr_badv         (excp_csr_badv),
    .excp_flush            (excp_flush),
    .excp_ifu_redirect_vld (excp_ifu_redirect_vld),
    .excp_ifu_redirect_pc  (excp_ifu_redirect_pc),
    .ifu_excp_redirect_rdy (ifu_excp_redirect_rdy),
    .excp_busy             (excp_busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; sample point sits 1 ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_req();
    ecl_valid_e = 0; ecl_excp_ine_e = 0; ecl_excp_brk_e = 0; ecl_excp_sys_e = 0;
    ecl_excp_ale_e = 0; ecl_ertn_e = 0;
  endtask

  task automatic drain(output int commits, output int ertns);
    commits = 0;
    ertns   = 0;
    for (int i = 0; i < 20 && excp_busy; i++) begin
      commits += int'(excp_csr_commit);
      ertns   += int'(excp_csr_ertn);
      tick();
    end
    check("drain_idle", excp_busy, 0);
  endtask

  int c, e, saw_vld;

  initial begin
    reset = 1; clear_req(); ifu_excp_redirect_rdy = 0;
    ifu_exu_pc_e = 0; exu_badv_e = 0; csr_eentry = 0; csr_era = 0;
    tick(); tick();
    reset = 0;
    tick();
    check("rst_commit", excp_csr_commit, 0);
    check("rst_flush", excp_flush, 0);
    check("rst_vld", excp_ifu_redirect_vld, 0);
    check("rst_busy", excp_busy, 0);
    check("rst_ecode", excp_csr_ecode, 0);

    // 1: ALE
    ecl_valid_e = 1; ecl_excp_ale_e = 1; ifu_exu_pc_e = 32'h1c000100;
    csr_eentry = 32'h1c008000; csr_era = 32'h1c00aaa0; exu_badv_e = 32'h00000013;
    tick(); clear_req(); ifu_exu_pc_e = 32'h0; csr_eentry = 32'h1c00dead;
    check("t1_commit", excp_csr_commit, 1);
    check("t1_ertn", excp_csr_ertn, 0);
    check("t1_ecode", excp_csr_ecode, 6'h09);
    check("t1_pc", excp_csr_pc, 32'h1c000100);
    check("t1_flush_a", excp_flush, 1);
    check("t1_busy", excp_busy, 1);
    tick();
    check("t1_commit_off", excp_csr_commit, 0);
    check("t1_flush_b", excp_flush, 1);
    check("t1_vld_early", excp_ifu_redirect_vld, 0);
    tick();
    check("t1_flush_end", excp_flush, 0);
    check("t1_vld", excp_ifu_redirect_vld, 1);
    check("t1_rpc", excp_ifu_redirect_pc, 32'h1c008000);
    ifu_excp_redirect_rdy = 1;
    tick();
    check("t1_idle", excp_busy, 0);
    check("t1_vld_off", excp_ifu_redirect_vld, 0);
`ifdef EXCP_BADV_EN
    check("t1_badv", excp_csr_badv, 32'h13);
`else
    check("t1_badv_tied", excp_csr_badv, 0);
`endif

    // 2: INE+ALE, rdy held high
    ecl_valid_e = 1; ecl_excp_ine_e = 1; ecl_excp_ale_e = 1; ifu_exu_pc_e = 32'h1c000200;
    csr_eentry = 32'h1c008000; exu_badv_e = 32'h00000077;
    tick(); clear_req();
    check("t2_ecode", excp_csr_ecode, 6'h0D);
    check("t2_pc", excp_csr_pc, 32'h1c000200);
    drain(c, e);
    check("t2_commits", c, 1);
    check("t2_ertns", e, 0);

    // 3: ERTN together with no exception
    ecl_valid_e = 1; ecl_ertn_e = 1; csr_era = 32'h1c000204; ifu_excp_redirect_rdy = 0;
    tick(); clear_req();
    check("t3_ertn", excp_csr_ertn, 1);
    check("t3_commit", excp_csr_commit, 0);
    check("t3_ecode_hold", excp_csr_ecode, 6'h0D);
    tick(); tick();
    check("t3_vld", excp_ifu_redirect_vld, 1);
    check("t3_rpc", excp_ifu_redirect_pc, 32'h1c000204);
    ifu_excp_redirect_rdy = 1;
    tick();
    check("t3_idle", excp_busy, 0);

    // 4: SYS, stall redirect 5 cycles, second SYS during busy dropped
    ifu_excp_redirect_rdy = 0;
    ecl_valid_e = 1; ecl_excp_sys_e = 1; ifu_exu_pc_e = 32'h1c000300; csr_eentry = 32'h1c009000;
    tick();
    check("t4_ecode", excp_csr_ecode, 6'h0B);
    ifu_exu_pc_e = 32'h1c000304; // valid/sys kept high: must be ignored
    tick(); tick();
    c = 0;
    for (int i = 0; i < 5; i++) begin
      check("t4_vld_stall", excp_ifu_redirect_vld, 1);
      check("t4_rpc_stall", excp_ifu_redirect_pc, 32'h1c009000);
      c += int'(excp_csr_commit);
      tick();
    end
    clear_req();
    check("t4_no_2nd_commit", c, 0);
    ifu_excp_redirect_rdy = 1;
    tick();
    check("t4_idle", excp_busy, 0);
    tick();
    check("t4_commit_quiet", excp_csr_commit, 0);
    check("t4_pc_hold", excp_csr_pc, 32'h1c000300);

    // 5: reset during FLUSH
    ecl_valid_e = 1; ecl_excp_brk_e = 1; ifu_exu_pc_e = 32'h1c000400;
    tick(); clear_req();
    check("t5_ecode", excp_csr_ecode, 6'h0C);
    tick();
    check("t5_in_flush", excp_flush, 1);
    reset = 1;
    tick();
    reset = 0;
    check("t5_busy", excp_busy, 0);
    check("t5_flush", excp_flush, 0);
    check("t5_commit", excp_csr_commit, 0);
    check("t5_ecode_rst", excp_csr_ecode, 0);
    check("t5_pc_rst", excp_csr_pc, 0);
    saw_vld = 0;
    for (int i = 0; i < 6; i++) begin
      saw_vld |= int'(excp_ifu_redirect_vld);
      tick();
    end
    check("t5_no_redir", saw_vld, 0);

`ifdef EXCP_BADV_EN
    // 6: badv captured on ALE, untouched by SYS
    ecl_valid_e = 1; ecl_excp_ale_e = 1; exu_badv_e = 32'h00000013;
    tick(); clear_req(); exu_badv_e = 32'h0000ffff;
    check("t6_badv", excp_csr_badv, 32'h13);
    drain(c, e);
    ecl_valid_e = 1; ecl_excp_sys_e = 1;
    tick(); clear_req();
    drain(c, e);
    check("t6_badv_hold", excp_csr_badv, 32'h13);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
